str_loader: RTL and testbench

STR_LOADER -- requirements
Module: str_loader

---
 rtl/str_pkg.sv | 17 +
 rtl/str_loader.sv | 90 +++++++++
 tb/tb_str_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/str_pkg.sv
// Shared constants and state encoding for the string loader.
// The loader's parameter defaults are taken from here.
package str_pkg;

  localparam int         MAXB = 17;
  localparam int         BW   = 141;
  localparam logic [7:0] NUL  = 8'h00;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    LAUNCH  = 3'd1,
    SETTLE  = 3'd2,
    WAIT    = 3'd3,
    REPORT  = 3'd4
  } state_t;

endpackage

// File: rtl/str_loader.sv
// Collects a NUL-terminated byte string, hands it to the counter stage and
// reports the latched result.
//   state   | meaning
//   COLLECT | accept bytes into B, count them in A
//   LAUNCH  | one-cycle start pulse to the counter stage
//   SETTLE  | ignore ack while the counter stage clears a stale one
//   WAIT    | wait for ack, then latch R into Count
//   REPORT  | one-cycle done pulse, clear A and B
module str_loader
  import str_pkg::*;
#(
  parameter int MAXB = str_pkg::MAXB,
  parameter int BW   = str_pkg::BW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [7:0]    In_data,
  input  logic          In_valid,
  output logic          In_ready,
  output logic [7:0]    A,
  output logic [BW-1:0] B,
  output logic          start,
  input  logic          ack,
  input  logic [7:0]    R,
  output logic [7:0]    Count,
  output logic          done,
  output logic          Ovf
);

  localparam logic [7:0] LAST_SLOT = 8'(MAXB - 1);

  state_t state_q, state_d;
  logic   is_nul, is_last;

  assign is_nul  = (In_data == NUL);
  assign is_last = (A == LAST_SLOT);

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (In_valid && (is_nul || is_last)) state_d = LAUNCH;
      LAUNCH:  state_d = SETTLE;
      SETTLE:  state_d = WAIT;
      WAIT:    if (ack) state_d = REPORT;
      REPORT:  state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  assign In_ready = (state_q == COLLECT);
  assign start    = (state_q == LAUNCH);
  assign done     = (state_q == REPORT);

  // Ovf only changes on the byte that ends a string, so it holds through the
  // whole launch/report of that string.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      A     <= '0;
      B     <= '0;
      Count <= '0;
      Ovf   <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (In_valid) begin
            if (is_nul) begin
              Ovf <= 1'b0;
            end else begin
              B[{A, 3'b000} +: 8] <= In_data;
              A                   <= A + 8'd1;
              if (is_last) Ovf <= 1'b1;
            end
          end
        end
        WAIT: if (ack) Count <= R;
        REPORT: begin
          A <= '0;
          B <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_str_loader.sv
// Bench for str_loader: drives byte streams, models the counter stage as an
// uppercase-letter counter, and compares against a string-splitting reference.
module tb_str_loader;

  localparam int TMAXB = 17;
  localparam int TBW   = 141;

  typedef logic [7:0] bq_t[$];

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic [7:0]     In_data = '0;
  logic           In_valid = 1'b0;
  logic           In_ready;
  logic [7:0]     A;
  logic [TBW-1:0] B;
  logic           start;
  logic           ack = 1'b0;
  logic [7:0]     R = '0;
  logic [7:0]     Count;
  logic           done;
  logic           Ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic model_en = 1'b1;
  logic stale_mode = 1'b0;

  logic           busy = 1'b0;
  logic [7:0]     hold_a;
  logic [TBW-1:0] hold_b;
  int             launch_a_q[$];
  logic [TBW-1:0] launch_b_q[$];
  int             start_cyc_q[$];
  logic [7:0]     done_count_q[$];
  logic           done_ovf_q[$];
  int             done_cyc_q[$];

  str_loader #(.MAXB(TMAXB), .BW(TBW)) dut (
    .Clk(Clk), .Rst(Rst), .In_data(In_data), .In_valid(In_valid),
    .In_ready(In_ready), .A(A), .B(B), .start(start), .ack(ack), .R(R),
    .Count(Count), .done(done), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [TBW-1:0] pack_str(input bq_t s);
    logic [TBW-1:0] v;
    v = '0;
    foreach (s[i]) v[8*i +: 8] = s[i];
    return v;
  endfunction

  function automatic logic [7:0] upper_cnt(input bq_t s);
    int n;
    n = 0;
    foreach (s[i]) if (s[i] >= 8'h41 && s[i] <= 8'h5A) n++;
    return 8'(n);
  endfunction

  // Monitor: snapshots each launch and report, and checks that the string is
  // frozen and input is refused while the counter stage owns it.
  always @(negedge Clk) begin
    if (Rst) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        checks++;
        if (In_ready !== 1'b0 || A !== hold_a || B !== hold_b) begin
          failures++;
          $display("FAIL busy_hold cyc=%0d In_ready=%b A=%0d held_A=%0d B_changed=%b",
                   cyc, In_ready, A, hold_a, (B !== hold_b));
        end
      end
      if (start) begin
        checks++;
        if (busy) begin
          failures++;
          $display("FAIL start_extra cyc=%0d start=1 while launch already active, required 0", cyc);
        end
        busy   = 1'b1;
        hold_a = A;
        hold_b = B;
        launch_a_q.push_back(int'(A));
        launch_b_q.push_back(B);
        start_cyc_q.push_back(cyc);
      end
      if (done) begin
        checks++;
        if (!busy) begin
          failures++;
          $display("FAIL done_unexpected cyc=%0d done=1 without a launch, required 0", cyc);
        end
        done_count_q.push_back(Count);
        done_ovf_q.push_back(Ovf);
        done_cyc_q.push_back(cyc);
        busy = 1'b0;
      end
    end
  end

  // Counter-stage model: clears ack on start, answers with the number of
  // uppercase letters in the launched string after a short delay.
  initial begin : counter_model
    logic [7:0] res;
    logic [7:0] c;
    forever begin
      @(negedge Clk);
      if (start && model_en && !Rst) begin
        res = '0;
        for (int i = 0; i < int'(A); i++) begin
          c = B[8*i +: 8];
          if (c >= 8'h41 && c <= 8'h5A) res++;
        end
        if (stale_mode) begin
          @(negedge Clk);
          @(posedge Clk);
          #1;
          ack = 1'b0;
          R   = '0;
          repeat (5) @(negedge Clk);
        end else begin
          ack = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge Clk);
        end
        R   = res;
        ack = 1'b1;
      end
    end
  end

  task automatic clear_mon();
    launch_a_q.delete();
    launch_b_q.delete();
    start_cyc_q.delete();
    done_count_q.delete();
    done_ovf_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if ($urandom_range(0, 2) == 0) begin
      In_valid = 1'b0;
      In_data  = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge Clk);
    end
    In_data  = b;
    In_valid = 1'b1;
    n = 0;
    while (In_ready !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h In_ready=%b required 1 within 200 cycles", b, In_ready);
    end
    @(negedge Clk);
    In_valid = 1'b0;
    In_data  = 8'($urandom);
  endtask

  task automatic run_stream(input bq_t s, input string name);
    bq_t        cur;
    int         exp_a[$];
    logic [TBW-1:0] exp_b[$];
    logic       exp_ovf[$];
    logic [7:0] exp_cnt[$];
    int         n;
    cur = {};
    foreach (s[k]) begin
      if (s[k] == 8'h00) begin
        exp_a.push_back(cur.size()); exp_b.push_back(pack_str(cur));
        exp_cnt.push_back(upper_cnt(cur)); exp_ovf.push_back(1'b0);
        cur = {};
      end else begin
        cur.push_back(s[k]);
        if (cur.size() == TMAXB) begin
          exp_a.push_back(cur.size()); exp_b.push_back(pack_str(cur));
          exp_cnt.push_back(upper_cnt(cur)); exp_ovf.push_back(1'b1);
          cur = {};
        end
      end
    end
    clear_mon();
    foreach (s[k]) send_byte(s[k]);
    n = 0;
    while (done_count_q.size() < exp_a.size() && n < 500) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (launch_a_q.size() != exp_a.size() || done_count_q.size() != exp_a.size()) begin
      failures++;
      $display("FAIL %s_strings launches=%0d reports=%0d required %0d",
               name, launch_a_q.size(), done_count_q.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < launch_a_q.size()) begin
        checks++;
        if (launch_a_q[i] != exp_a[i]) begin
          failures++;
          $display("FAIL %s_A[%0d] got %0d required %0d", name, i, launch_a_q[i], exp_a[i]);
        end
        checks++;
        if (launch_b_q[i] !== exp_b[i]) begin
          failures++;
          $display("FAIL %s_B[%0d] got %h required %h", name, i, launch_b_q[i], exp_b[i]);
        end
      end
      if (i < done_count_q.size()) begin
        checks++;
        if (done_count_q[i] !== exp_cnt[i]) begin
          failures++;
          $display("FAIL %s_Count[%0d] got %0d required %0d", name, i, done_count_q[i], exp_cnt[i]);
        end
        checks++;
        if (done_ovf_q[i] !== exp_ovf[i]) begin
          failures++;
          $display("FAIL %s_Ovf[%0d] got %b required %b", name, i, done_ovf_q[i], exp_ovf[i]);
        end
      end
    end
    @(negedge Clk);
    checks++;
    if (A !== 8'd0 || B !== '0 || In_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_cleared A=%0d B_zero=%b In_ready=%b required 0/1/1",
               name, A, (B == '0), In_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (A !== 8'd0 || B !== '0 || start !== 1'b0 || Count !== 8'd0 ||
        done !== 1'b0 || Ovf !== 1'b0 || In_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s A=%0d Bz=%b start=%b Count=%0d done=%b Ovf=%b In_ready=%b required 0 1 0 0 0 0 1",
               name, A, (B == '0), start, Count, done, Ovf, In_ready);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset_init");
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    run_stream({8'h41, 8'h62, 8'h63, 8'h64, 8'h45, 8'h66, 8'h67, 8'h68, 8'h00}, "basic");
  endtask

  task automatic test_empty();
    run_stream({8'h00}, "empty");
  endtask

  task automatic test_overflow();
    bq_t s;
    s = {};
    repeat (20) s.push_back(8'h5A);
    s.push_back(8'h00);
    run_stream(s, "overflow");
  endtask

  task automatic test_stale_ack();
    ack = 1'b1;
    R   = 8'd99;
    stale_mode = 1'b1;
    run_stream({8'h41, 8'h42, 8'h43, 8'h00}, "stale");
    checks++;
    if (start_cyc_q.size() != 1 || done_cyc_q.size() != 1) begin
      failures++;
      $display("FAIL stale_timing launches=%0d reports=%0d required 1",
               start_cyc_q.size(), done_cyc_q.size());
    end else if (done_cyc_q[0] - start_cyc_q[0] != 7) begin
      failures++;
      $display("FAIL stale_timing done after %0d cycles required 7",
               done_cyc_q[0] - start_cyc_q[0]);
    end
    stale_mode = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int n;
    model_en = 1'b0;
    ack = 1'b0;
    clear_mon();
    repeat (TMAXB) send_byte(8'h51);
    n = 0;
    while (launch_a_q.size() == 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (launch_a_q.size() == 0) begin
      failures++;
      $display("FAIL rstwait_launch launches=0 required 1");
    end
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    #1;
    check_reset_outputs("rstwait_outputs");
    Rst = 1'b0;
    ack = 1'b1;
    R   = 8'd7;
    repeat (6) @(negedge Clk);
    checks++;
    if (done_count_q.size() != 0 || Count !== 8'd0) begin
      failures++;
      $display("FAIL rstwait_late_ack reports=%0d Count=%0d required 0 and 0",
               done_count_q.size(), Count);
    end
    ack = 1'b0;
    model_en = 1'b1;
    run_stream({8'h4F, 8'h6B, 8'h00}, "rstwait_recover");
  endtask

  task automatic test_toggle_hello();
    run_stream({8'h48, 8'h65, 8'h4C, 8'h4C, 8'h6F, 8'h00}, "hello");
  endtask

  task automatic test_random();
    bq_t s;
    int  len;
    int  pick;
    for (int t = 0; t < 4; t++) begin
      s = {};
      len = $urandom_range(5, 40);
      for (int i = 0; i < len; i++) begin
        pick = $urandom_range(0, 9);
        if (pick == 0)      s.push_back(8'h00);
        else if (pick < 4)  s.push_back(8'($urandom_range(8'h41, 8'h5A)));
        else                s.push_back(8'($urandom_range(1, 255)));
      end
      s.push_back(8'h00);
      run_stream(s, $sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_stale_ack();
    test_reset_in_wait();
    test_toggle_hello();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
